// File: rtl/rf_cmd_ctrl_if.sv
// Byte-stream, register-file and UART-TX signals of the command controller.
// The slave modport is the controller's view; master is the surrounding system.
interface rf_cmd_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
);
  logic [WIDTH-1:0] rx_p_data;
  logic             rx_d_vld;
  logic [WIDTH-1:0] rd_data;
  logic             rd_data_valid;
  logic             tx_busy;
  logic             wr_en;
  logic             rd_en;
  logic [ADDR-1:0]  address;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] tx_p_data;
  logic             tx_d_vld;
  logic             ctrl_busy;
  logic             rd_timeout;

  modport master (
    output rx_p_data, rx_d_vld, rd_data, rd_data_valid, tx_busy,
    input  wr_en, rd_en, address, wr_data, tx_p_data, tx_d_vld, ctrl_busy, rd_timeout
  );

  modport slave (
    input  rx_p_data, rx_d_vld, rd_data, rd_data_valid, tx_busy,
    output wr_en, rd_en, address, wr_data, tx_p_data, tx_d_vld, ctrl_busy, rd_timeout
  );
endinterface

// File: rtl/rf_cmd_ctrl.sv
// Decodes {CMD_WR,addr,data} / {CMD_RD,addr} byte frames into register-file strobes
// and returns one reply byte per read, substituting ERR_BYTE if the register file never answers.
module rf_cmd_ctrl #(
  parameter int               WIDTH    = 8,
  parameter int               ADDR     = 4,
  parameter logic [WIDTH-1:0] CMD_WR   = 8'hAA,
  parameter logic [WIDTH-1:0] CMD_RD   = 8'hBB,
  parameter int               TIMEOUT  = 16,
  parameter logic [WIDTH-1:0] ERR_BYTE = 8'hEE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  rf_cmd_ctrl_if.slave bus
);

  localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_TX_SEND = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_wr_en;
  logic             w_wr_en;
  logic             r_rd_en;
  logic             w_rd_en;
  logic [ADDR-1:0]  r_address;
  logic [ADDR-1:0]  w_address;
  logic [WIDTH-1:0] r_wr_data;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] r_tx_byte;
  logic [WIDTH-1:0] w_tx_byte;
  logic             r_timeout;
  logic             w_timeout;
  logic             r_busy;
  logic             w_tx_vld;

  // Next-state and next-output decode for the frame parser, read watchdog and TX hand-off.
  always_comb begin
    w_next_state = r_state;
    w_cnt        = r_cnt;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_address    = r_address;
    w_wr_data    = r_wr_data;
    w_tx_byte    = r_tx_byte;
    w_timeout    = r_timeout;
    w_tx_vld     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_d_vld && (bus.rx_p_data == CMD_WR)) begin
          w_next_state = S_WR_ADDR;
          w_timeout    = 1'b0;
        end else if (bus.rx_d_vld && (bus.rx_p_data == CMD_RD)) begin
          w_next_state = S_RD_ADDR;
          w_timeout    = 1'b0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WR_ADDR: begin
        if (bus.rx_d_vld) begin
          w_address    = bus.rx_p_data[ADDR-1:0];
          w_next_state = S_WR_DATA;
        end else begin
          w_next_state = S_WR_ADDR;
        end
      end
      S_WR_DATA: begin
        if (bus.rx_d_vld) begin
          w_wr_data    = bus.rx_p_data;
          w_wr_en      = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WR_DATA;
        end
      end
      S_RD_ADDR: begin
        if (bus.rx_d_vld) begin
          w_address    = bus.rx_p_data[ADDR-1:0];
          w_rd_en      = 1'b1;
          w_cnt        = {CNT_W{1'b0}};
          w_next_state = S_RD_WAIT;
        end else begin
          w_next_state = S_RD_ADDR;
        end
      end
      S_RD_WAIT: begin
        // Read data is checked before expiry so a reply on the last cycle still wins.
        if (bus.rd_data_valid) begin
          w_tx_byte    = bus.rd_data;
          w_next_state = S_TX_SEND;
        end else if (r_cnt == CNT_MAX) begin
          w_tx_byte    = ERR_BYTE;
          w_timeout    = 1'b1;
          w_next_state = S_TX_SEND;
        end else begin
          w_cnt        = r_cnt + CNT_ONE;
          w_next_state = S_RD_WAIT;
        end
      end
      S_TX_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_vld     = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_TX_SEND;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered strobes, latched address/data/reply byte, watchdog and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_address <= {ADDR{1'b0}};
      r_wr_data <= {WIDTH{1'b0}};
      r_tx_byte <= {WIDTH{1'b0}};
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt;
      r_wr_en   <= w_wr_en;
      r_rd_en   <= w_rd_en;
      r_address <= w_address;
      r_wr_data <= w_wr_data;
      r_tx_byte <= w_tx_byte;
      r_timeout <= w_timeout;
      r_busy    <= (w_next_state != S_IDLE);
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.rd_en      = r_rd_en;
  assign bus.address    = r_address;
  assign bus.wr_data    = r_wr_data;
  assign bus.tx_p_data  = r_tx_byte;
  // Qualified by the live TX_BUSY so the strobe can never coincide with a busy transmitter.
  assign bus.tx_d_vld   = w_tx_vld;
  assign bus.ctrl_busy  = r_busy;
  assign bus.rd_timeout = r_timeout;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Scoreboard bench for rf_cmd_ctrl: stimulus pushes expected writes/replies, a negedge monitor pops and compares.
module tb_rf_cmd_ctrl;

  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_cmd_ctrl_if #(.WIDTH(8), .ADDR(4)) bus ();

  rf_cmd_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] ref_mem [16];
  logic [7:0] rf_mem  [16];
  wr_exp_t    wr_q [$];
  logic [8:0] tx_q [$];
  bit         rd_allow = 1'b0;
  wr_exp_t    mon_we;
  logic [8:0] mon_te;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the register-file side and the TX side, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        rf_mem[bus.address] <= bus.wr_data;
        check("wren_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          mon_we = wr_q.pop_front();
          check("write_addr_data", 32'({bus.address, bus.wr_data}), 32'({mon_we.addr, mon_we.data}));
        end
        check("wren_rden_exclusive", 32'(bus.rd_en), 32'd0);
      end
      if (bus.rd_en) begin
        check("rden_expected", 32'(rd_allow), 32'd1);
      end
      if (bus.tx_d_vld) begin
        check("txvld_not_busy", 32'(bus.tx_busy), 32'd0);
        check("txvld_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          mon_te = tx_q.pop_front();
          check("tx_byte_and_timeout", 32'({bus.rd_timeout, bus.tx_p_data}), 32'(mon_te));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_p_data = b;
    bus.rx_d_vld  = 1'b1;
    tick();
    bus.rx_d_vld  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic [3:0] ai;
    ai = a[3:0];
    wr_q.push_back({ai, d});
    ref_mem[ai] = d;
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
  endtask

  // d = cycles from RdEn to RdData_Valid (1..TIMEOUT answers in time); d = 0 means no answer at all.
  task automatic do_read(input logic [7:0] a, input int d, input bit junk, input int busy);
    logic [3:0] ai;
    logic [7:0] jb;
    int         n;
    ai = a[3:0];
    if (d >= 1 && d <= TIMEOUT) tx_q.push_back({1'b0, ref_mem[ai]});
    else                        tx_q.push_back({1'b1, 8'hEE});
    bus.tx_busy = (busy > 0);
    send_byte(8'hBB);
    rd_allow = 1'b1;
    send_byte(a);
    n = 0;
    while (!bus.rd_en && n < 8) begin
      tick();
      n++;
    end
    check("rden_seen", 32'(bus.rd_en), 32'd1);
    bus.rd_data = rf_mem[bus.address];
    if (junk) begin
      case ($urandom_range(0, 2))
        0:       jb = 8'hAA;
        1:       jb = 8'hBB;
        default: jb = 8'($urandom_range(0, 255));
      endcase
      send_byte(jb);
    end else begin
      tick();
    end
    rd_allow = 1'b0;
    if (d >= 1 && d <= TIMEOUT) begin
      repeat (d - 1) tick();
      bus.rd_data_valid = 1'b1;
      tick();
      bus.rd_data_valid = 1'b0;
    end else begin
      repeat (TIMEOUT + 1) tick();
    end
    repeat (busy) tick();
    bus.tx_busy = 1'b0;
    n = 0;
    while (bus.ctrl_busy && n < 100) begin
      tick();
      n++;
    end
    check("read_completes", 32'(bus.ctrl_busy), 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({bus.wr_en, bus.rd_en, bus.address, bus.wr_data, bus.tx_p_data,
                bus.tx_d_vld, bus.ctrl_busy, bus.rd_timeout});
  endfunction

  initial begin
    int         n;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'h00;
      rf_mem[i]  = 8'h00;
    end
    bus.rx_p_data     = 8'h00;
    bus.rx_d_vld      = 1'b0;
    bus.rd_data       = 8'h00;
    bus.rd_data_valid = 1'b0;
    bus.tx_busy       = 1'b0;
    repeat (3) tick();
    check("reset_outputs_zero", all_outputs(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain write, then the controller must be idle with address/data held.
    do_write(8'h05, 8'h0A);
    tick();
    check("write_idle_after", 32'(bus.ctrl_busy), 32'd0);
    check("addr_data_hold", 32'({bus.address, bus.wr_data}), 32'h50A);

    do_read(8'h05, 1, 1'b0, 0);
    do_read(8'h05, 1, 1'b0, 20);

    do_read(8'h03, 0, 1'b0, 0);
    check("timeout_sticky", 32'(bus.rd_timeout), 32'd1);
    wr_q.push_back({4'h1, 8'h22});
    ref_mem[1] = 8'h22;
    send_byte(8'hAA);
    check("timeout_cleared_by_opcode", 32'(bus.rd_timeout), 32'd0);
    send_byte(8'h01);
    send_byte(8'h22);

    // Reply on the very cycle the watchdog expires: data wins.
    do_read(8'h01, TIMEOUT, 1'b1, 0);

    send_byte(8'h55);
    check("ignored_byte_idle", 32'(bus.ctrl_busy), 32'd0);
    do_write(8'hF2, 8'hBB);
    do_write(8'h0C, 8'hAA);
    do_read(8'h02, 3, 1'b1, 2);
    do_read(8'h0C, 5, 1'b1, 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        4, 5, 6, 7: do_read(8'($urandom_range(0, 255)),
                            ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT)),
                            1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hAA || b == 8'hBB) b = 8'h55;
          send_byte(b);
          check("random_ignored_byte", 32'(bus.ctrl_busy), 32'd0);
        end
      endcase
    end

    // Reset mid-frame: abandon AA,07 with no strobe, then a lone data byte must do nothing.
    send_byte(8'hAA);
    send_byte(8'h07);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_zero", all_outputs(), 32'd0);
    tick();
    rst_n = 1'b1;
    send_byte(8'h09);
    repeat (4) tick();
    check("post_reset_idle", 32'(bus.ctrl_busy), 32'd0);

    n = 0;
    while ((wr_q.size() + tx_q.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(wr_q.size() + tx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
